zbb_iter_unit: RTL and testbench

- Parametrised, handshaked successor to the combinational Zbb block.
- Executes the RV32/RV64 Zbb subset: the logic, min/max and extend ops, plus rol/ror/rori/rev8/orc.b.
- clz/ctz/cpop run iteratively, CHUNK bits per cycle, trading latency for area; all other ops return in one cycle.
- Sits beside the ALU in the execute stage; the core stalls while in_ready=0 or while waiting for out_valid.

---
 rtl/zbb_iter_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_zbb_iter_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/zbb_iter_unit.sv
// Handshaked Zbb execute unit: logic/min/max/extend/rotate/byte ops return in one cycle,
// clz/ctz/cpop walk the operand CHUNK bits per cycle.
module zbb_iter_unit #(
  parameter int XLEN       = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] din_rs1,
  input  logic [XLEN-1:0] din_rs2,
  input  logic [6:0]      cmdOp,
  input  logic [2:0]      cmdF3,
  input  logic [6:0]      cmdF7,
  input  logic [11:0]     immI,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] dout_rd,
  output logic            isZbbInstr,
  output logic            busy
);
  localparam int N  = XLEN / CHUNK;
  localparam int SW = $clog2(XLEN);
  localparam int AW = SW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [6:0]    OP_R     = 7'b0110011;
  localparam logic [6:0]    OP_I     = 7'b0010011;
  localparam logic [6:0]    OP_ZEXTH = (XLEN == 64) ? 7'b0111011 : 7'b0110011;
  localparam logic [11:0]   IMM_REV8 = (XLEN == 64) ? 12'h6B8 : 12'h698;
  localparam logic [AW-1:0] ONE      = AW'(1);

  // state | meaning
  // IDLE  | accepting a request
  // COUNT | clz/ctz/cpop in progress, one chunk per cycle
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  typedef enum logic [1:0] {CNT_CLZ, CNT_CTZ, CNT_POP} cnt_op_t;

  state_t          state_q, state_d;
  cnt_op_t         op_q, op_d;
  logic [XLEN-1:0] scan_q, scan_d;
  logic [XLEN-1:0] dout_q, dout_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            found_q, found_d;
  logic            zbb_q, zbb_d;

  function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] v, input logic [SW-1:0] s);
    logic [SW-1:0] sn;
    sn = -s;
    return (v >> s) | (v << sn);
  endfunction

  logic [SW-1:0]   rs2_sh, rs2_neg;
  logic            rori_hit;
  logic [XLEN-1:0] orc_res, rev8_res;

  assign rs2_sh   = din_rs2[SW-1:0];
  assign rs2_neg  = -rs2_sh;
  assign rori_hit = (XLEN == 64) ? (immI[11:6] == 6'b011000) : (immI[11:5] == 7'b0110000);

  always_comb begin
    orc_res  = '0;
    rev8_res = '0;
    for (int i = 0; i < XLEN / 8; i++) begin
      orc_res[i*8 +: 8]  = {8{|din_rs1[i*8 +: 8]}};
      rev8_res[i*8 +: 8] = din_rs1[XLEN-8-i*8 +: 8];
    end
  end

  logic            dec_zbb, dec_cnt;
  cnt_op_t         dec_op;
  logic [XLEN-1:0] dec_res;

  always_comb begin
    dec_zbb = 1'b0;
    dec_cnt = 1'b0;
    dec_op  = CNT_CLZ;
    dec_res = '0;
    if (cmdOp == OP_R && cmdF7 == 7'b0100000) begin
      case (cmdF3)
        3'b111:  begin dec_zbb = 1'b1; dec_res = din_rs1 & ~din_rs2; end
        3'b110:  begin dec_zbb = 1'b1; dec_res = din_rs1 | ~din_rs2; end
        3'b100:  begin dec_zbb = 1'b1; dec_res = ~(din_rs1 ^ din_rs2); end
        default: ;
      endcase
    end else if (cmdOp == OP_R && cmdF7 == 7'b0000101) begin
      dec_zbb = 1'b1;
      case (cmdF3)
        3'b110:  dec_res = ($signed(din_rs1) > $signed(din_rs2)) ? din_rs1 : din_rs2;
        3'b111:  dec_res = (din_rs1 > din_rs2) ? din_rs1 : din_rs2;
        3'b100:  dec_res = ($signed(din_rs1) < $signed(din_rs2)) ? din_rs1 : din_rs2;
        3'b101:  dec_res = (din_rs1 < din_rs2) ? din_rs1 : din_rs2;
        default: dec_zbb = 1'b0;
      endcase
    end else if (cmdOp == OP_R && cmdF7 == 7'b0110000 && (cmdF3 == 3'b001 || cmdF3 == 3'b101)) begin
      dec_zbb = 1'b1;
      dec_res = cmdF3[2] ? rotr(din_rs1, rs2_sh) : rotr(din_rs1, rs2_neg);
    end else if (cmdOp == OP_ZEXTH && cmdF7 == 7'b0000100 && cmdF3 == 3'b100 && immI == 12'h080) begin
      dec_zbb = 1'b1;
      dec_res = {{(XLEN-16){1'b0}}, din_rs1[15:0]};
    end else if (cmdOp == OP_I && cmdF3 == 3'b001) begin
      case (immI)
        12'h600: begin dec_zbb = 1'b1; dec_cnt = 1'b1; dec_op = CNT_CLZ; end
        12'h601: begin dec_zbb = 1'b1; dec_cnt = 1'b1; dec_op = CNT_CTZ; end
        12'h602: begin dec_zbb = 1'b1; dec_cnt = 1'b1; dec_op = CNT_POP; end
        12'h604: begin dec_zbb = 1'b1; dec_res = {{(XLEN-8){din_rs1[7]}}, din_rs1[7:0]}; end
        12'h605: begin dec_zbb = 1'b1; dec_res = {{(XLEN-16){din_rs1[15]}}, din_rs1[15:0]}; end
        default: ;
      endcase
    end else if (cmdOp == OP_I && cmdF3 == 3'b101) begin
      if (immI == 12'h287) begin
        dec_zbb = 1'b1;
        dec_res = orc_res;
      end else if (immI == IMM_REV8) begin
        dec_zbb = 1'b1;
        dec_res = rev8_res;
      end else if (rori_hit) begin
        dec_zbb = 1'b1;
        dec_res = rotr(din_rs1, immI[SW-1:0]);
      end
    end
  end

  // clz consumes the top chunk and shifts left; ctz/cpop consume the bottom chunk and shift right
  logic [CHUNK-1:0] chunk;
  logic [AW-1:0]    chunk_cnt;
  logic             chunk_nz, seen;

  always_comb begin
    chunk     = (op_q == CNT_CLZ) ? scan_q[XLEN-1 -: CHUNK] : scan_q[CHUNK-1:0];
    chunk_nz  = |chunk;
    chunk_cnt = '0;
    seen      = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      case (op_q)
        CNT_CLZ: begin
          if (chunk[CHUNK-1-i]) seen = 1'b1;
          else if (!seen) chunk_cnt = chunk_cnt + ONE;
        end
        CNT_CTZ: begin
          if (chunk[i]) seen = 1'b1;
          else if (!seen) chunk_cnt = chunk_cnt + ONE;
        end
        default: chunk_cnt = chunk_cnt + AW'(chunk[i]);
      endcase
    end
  end

  logic [AW-1:0] acc_sum;
  logic          stop_scan;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    scan_d    = scan_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    found_d   = found_q;
    dout_d    = dout_q;
    zbb_d     = zbb_q;
    acc_sum   = found_q ? acc_q : acc_q + chunk_cnt;
    stop_scan = (op_q != CNT_POP) && chunk_nz;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_cnt) begin
            state_d = COUNT;
            op_d    = dec_op;
            scan_d  = din_rs1;
            acc_d   = '0;
            idx_d   = '0;
            found_d = 1'b0;
          end else begin
            state_d = DONE;
            dout_d  = dec_res;
            zbb_d   = dec_zbb;
          end
        end
      end
      COUNT: begin
        scan_d  = (op_q == CNT_CLZ) ? (scan_q << CHUNK) : (scan_q >> CHUNK);
        idx_d   = idx_q + IW'(1);
        acc_d   = acc_sum;
        found_d = found_q | stop_scan;
        if (idx_q == IW'(N - 1) || (EARLY_EXIT && stop_scan)) begin
          state_d = DONE;
          dout_d  = {{(XLEN-AW){1'b0}}, acc_sum};
          zbb_d   = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= CNT_CLZ;
      scan_q  <= '0;
      dout_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      zbb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      scan_q  <= scan_d;
      dout_q  <= dout_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      zbb_q   <= zbb_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign dout_rd    = dout_q;
  assign isZbbInstr = zbb_q;

endmodule

// File: tb/tb_zbb_iter_unit.sv
// Bench for zbb_iter_unit: three configurations (32/8 no early exit, 32/8 early exit, 64/16 early exit)
// checked against an arithmetic reference model.
module tb_zbb_iter_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv, ordy, ir, ov, isz, bsy;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [11:0] imm;
  logic [63:0] a, b;
  logic [31:0] d0, d1;
  logic [63:0] d2;
  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  zbb_iter_unit #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .din_rs1(a[31:0]), .din_rs2(b[31:0]),
    .cmdOp(op), .cmdF3(f3), .cmdF7(f7), .immI(imm), .out_valid(ov[0]), .out_ready(ordy[0]),
    .dout_rd(d0), .isZbbInstr(isz[0]), .busy(bsy[0]));
  zbb_iter_unit #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .din_rs1(a[31:0]), .din_rs2(b[31:0]),
    .cmdOp(op), .cmdF3(f3), .cmdF7(f7), .immI(imm), .out_valid(ov[1]), .out_ready(ordy[1]),
    .dout_rd(d1), .isZbbInstr(isz[1]), .busy(bsy[1]));
  zbb_iter_unit #(.XLEN(64), .CHUNK(16), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .din_rs1(a), .din_rs2(b),
    .cmdOp(op), .cmdF3(f3), .cmdF7(f7), .immI(imm), .out_valid(ov[2]), .out_ready(ordy[2]),
    .dout_rd(d2), .isZbbInstr(isz[2]), .busy(bsy[2]));

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;
  localparam logic [6:0] W = 7'b0111011;

  function automatic logic [63:0] dsel(input int d);
    if (d == 0) return {32'b0, d0};
    if (d == 1) return {32'b0, d1};
    return d2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int s, input int xlen, input logic [63:0] m);
    if (s == 0) return v;
    return ((v >> s) | (v << (xlen - s))) & m;
  endfunction

  // kind: 0 single-cycle, 1 clz, 2 ctz, 3 cpop
  function automatic void model(input int xlen, input logic [6:0] o, input logic [2:0] g3,
                                input logic [6:0] g7, input logic [11:0] im,
                                input logic [63:0] ra_in, input logic [63:0] rb_in,
                                output logic [63:0] res, output logic z, output int kind);
    logic [63:0] m, ra, rb;
    longint sa, sb;
    int sh, cnt;
    m  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ra = ra_in & m;
    rb = rb_in & m;
    sa = (xlen == 64) ? longint'(ra) : longint'($signed(ra[31:0]));
    sb = (xlen == 64) ? longint'(rb) : longint'($signed(rb[31:0]));
    sh = int'(rb % 64'(xlen));
    res = '0; z = 1'b1; kind = 0; cnt = 0;
    if (o == R && g7 == 7'b0100000 && g3 == 3'b111) res = ra & ~rb;
    else if (o == R && g7 == 7'b0100000 && g3 == 3'b110) res = (ra | ~rb) & m;
    else if (o == R && g7 == 7'b0100000 && g3 == 3'b100) res = ~(ra ^ rb) & m;
    else if (o == R && g7 == 7'b0000101 && g3 == 3'b110) res = (sa > sb) ? ra : rb;
    else if (o == R && g7 == 7'b0000101 && g3 == 3'b111) res = (ra > rb) ? ra : rb;
    else if (o == R && g7 == 7'b0000101 && g3 == 3'b100) res = (sa < sb) ? ra : rb;
    else if (o == R && g7 == 7'b0000101 && g3 == 3'b101) res = (ra < rb) ? ra : rb;
    else if (o == R && g7 == 7'b0110000 && g3 == 3'b001) res = rotr(ra, (xlen - sh) % xlen, xlen, m);
    else if (o == R && g7 == 7'b0110000 && g3 == 3'b101) res = rotr(ra, sh, xlen, m);
    else if (o == ((xlen == 64) ? W : R) && g7 == 7'b0000100 && g3 == 3'b100 && im == 12'h080)
      res = ra & 64'hFFFF;
    else if (o == I && g3 == 3'b001 && im == 12'h600) begin
      kind = 1;
      for (int i = xlen - 1; i >= 0 && !ra[i]; i--) cnt++;
      res = 64'(cnt);
    end else if (o == I && g3 == 3'b001 && im == 12'h601) begin
      kind = 2;
      for (int i = 0; i < xlen && !ra[i]; i++) cnt++;
      res = 64'(cnt);
    end else if (o == I && g3 == 3'b001 && im == 12'h602) begin
      kind = 3;
      res = 64'($countones(ra));
    end else if (o == I && g3 == 3'b001 && im == 12'h604) res = 64'(longint'($signed(ra[7:0]))) & m;
    else if (o == I && g3 == 3'b001 && im == 12'h605) res = 64'(longint'($signed(ra[15:0]))) & m;
    else if (o == I && g3 == 3'b101 && im == 12'h287) begin
      for (int i = 0; i < xlen / 8; i++) if (((ra >> (8 * i)) & 64'hFF) != 0) res |= 64'hFF << (8 * i);
    end else if (o == I && g3 == 3'b101 && im == ((xlen == 64) ? 12'h6B8 : 12'h698)) begin
      for (int i = 0; i < xlen / 8; i++) res |= ((ra >> (8 * i)) & 64'hFF) << (xlen - 8 - 8 * i);
    end else if (o == I && g3 == 3'b101 &&
                 ((xlen == 32) ? (im[11:5] == 7'b0110000) : (im[11:6] == 6'b011000)))
      res = rotr(ra, int'(im) % xlen, xlen, m);
    else z = 1'b0;
  endfunction

  task automatic do_op(input int d, input logic [6:0] o, input logic [2:0] g3, input logic [6:0] g7,
                       input logic [11:0] im, input logic [63:0] ra, input logic [63:0] rb,
                       input int hold, input string tag);
    logic [63:0] er;
    logic ez;
    int kind, xlen, chn, n, elat, lat;
    xlen = (d == 2) ? 64 : 32;
    chn  = (d == 2) ? 16 : 8;
    n    = xlen / chn;
    model(xlen, o, g3, g7, im, ra, rb, er, ez, kind);
    if (kind == 0) elat = 1;
    else if (kind == 3 || d == 0 || (ra & ((xlen == 64) ? '1 : 64'hFFFF_FFFF)) == 0) elat = n + 1;
    else elat = int'(er) / chn + 2;
    chk({tag, " in_ready idle"}, ir[d], 1'b1);
    op = o; f3 = g3; f7 = g7; imm = im; a = ra; b = rb;
    iv[d] = 1'b1;
    ordy[d] = (hold == 0);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    a = {$urandom, $urandom};
    lat = 1;
    while (!ov[d] && lat < 200) begin
      chk({tag, " in_ready busy"}, ir[d], 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " dout"}, dsel(d), er);
    chk({tag, " isZbb"}, isz[d], ez);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk({tag, " held dout"}, dsel(d), er);
        chk({tag, " held valid"}, ov[d], 1'b1);
        chk({tag, " held in_ready"}, ir[d], 1'b0);
      end
      ordy[d] = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, " in_ready after"}, ir[d], 1'b1);
    chk({tag, " valid after"}, ov[d], 1'b0);
    ordy[d] = 1'b0;
  endtask

  initial begin
    logic [6:0] ro, r7;
    logic [2:0] r3;
    logic [11:0] ri;
    logic [63:0] ra, rb;
    int d, s;
    rst = 1'b1; iv = '0; ordy = '0; op = '0; f3 = '0; f7 = '0; imm = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset out_valid", ov[k], 1'b0);
      chk("reset dout", dsel(k), 64'h0);
      chk("reset isZbb", isz[k], 1'b0);
      chk("reset busy", bsy[k], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk("in_ready after reset", ir[k], 1'b1);

    do_op(0, I, 3'b001, 7'h00, 12'h600, 64'h0001_0000, 64'h0, 0, "clz noee");
    do_op(1, I, 3'b001, 7'h00, 12'h601, 64'h0000_0100, 64'h0, 0, "ctz ee");
    do_op(1, I, 3'b001, 7'h00, 12'h601, 64'h0, 64'h0, 0, "ctz zero");
    do_op(0, I, 3'b001, 7'h00, 12'h600, 64'h0, 64'h0, 0, "clz zero");
    do_op(1, I, 3'b001, 7'h00, 12'h602, 64'hFFFF_FFFF, 64'h0, 0, "cpop ones");
    do_op(1, R, 3'b110, 7'b0000101, 12'h0A1, 64'hFFFF_FFFF, 64'h1, 0, "max");
    do_op(1, R, 3'b111, 7'b0000101, 12'h0A1, 64'hFFFF_FFFF, 64'h1, 0, "maxu");
    do_op(1, I, 3'b101, 7'h00, 12'h601, 64'h8000_0001, 64'h0, 0, "rori");
    do_op(1, I, 3'b101, 7'h00, 12'h698, 64'h1122_3344, 64'h0, 0, "rev8");
    do_op(1, I, 3'b101, 7'h00, 12'h287, 64'h0012_0300, 64'h0, 0, "orc.b");
    do_op(1, I, 3'b001, 7'h00, 12'h602, 64'h1234_5678, 64'h0, 4, "cpop hold");

    op = I; f3 = 3'b001; imm = 12'h600; a = 64'h1; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid-count busy", bsy[0], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid-count valid", ov[0], 1'b0);
    chk("rst mid-count busy", bsy[0], 1'b0);
    chk("rst mid-count in_ready", ir[0], 1'b1);
    ordy[0] = 1'b0;
    do_op(0, I, 3'b001, 7'h00, 12'h601, 64'h0000_8000, 64'h0, 0, "ctz after rst");

    do_op(2, I, 3'b001, 7'h00, 12'h600, 64'h1, 64'h0, 0, "clz64");
    do_op(2, W, 3'b000, 7'h00, 12'h005, 64'h1234, 64'h5678, 0, "add.w");
    do_op(2, I, 3'b101, 7'h00, 12'h6B8, 64'h0102_0304_0506_0708, 64'h0, 0, "rev8 64");

    for (int t = 0; t < 80; t++) begin
      d  = int'($urandom_range(0, 2));
      s  = int'($urandom_range(0, 18));
      ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb = {$urandom, $urandom};
      r7 = 7'($urandom);
      ri = 12'($urandom);
      ro = R;
      r3 = 3'b000;
      case (s)
        0:  begin r7 = 7'b0100000; r3 = 3'b111; end
        1:  begin r7 = 7'b0100000; r3 = 3'b110; end
        2:  begin r7 = 7'b0100000; r3 = 3'b100; end
        3:  begin r7 = 7'b0000101; r3 = 3'b110; end
        4:  begin r7 = 7'b0000101; r3 = 3'b111; end
        5:  begin r7 = 7'b0000101; r3 = 3'b100; end
        6:  begin r7 = 7'b0000101; r3 = 3'b101; end
        7:  begin r7 = 7'b0110000; r3 = 3'b001; end
        8:  begin r7 = 7'b0110000; r3 = 3'b101; end
        9:  begin ro = (d == 2) ? W : R; r7 = 7'b0000100; r3 = 3'b100; ri = 12'h080; end
        10: begin ro = I; r3 = 3'b001; ri = 12'h600; end
        11: begin ro = I; r3 = 3'b001; ri = 12'h601; end
        12: begin ro = I; r3 = 3'b001; ri = 12'h602; end
        13: begin ro = I; r3 = 3'b001; ri = 12'h604; end
        14: begin ro = I; r3 = 3'b001; ri = 12'h605; end
        15: begin ro = I; r3 = 3'b101; ri = 12'h287; end
        16: begin ro = I; r3 = 3'b101; ri = (d == 2) ? 12'h6B8 : 12'h698; end
        17: begin ro = I; r3 = 3'b101; ri = (d == 2) ? {6'b011000, 6'($urandom)} : {7'b0110000, 5'($urandom)}; end
        default: begin ro = 7'($urandom); r3 = 3'($urandom); end
      endcase
      if (s <= 8) ri = {r7, 5'($urandom)};
      do_op(d, ro, r3, r7, ri, ra, rb, (t % 7 == 3) ? 2 : 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
